wb_rr_arbiter: RTL and testbench
================================

// Module: wb_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one Wishbone slave port between N masters.
//  Typical masters: the UART debug bridge and a local CPU or DMA.
//  Holds the grant for a whole cycle and enforces a bus timeout watchdog.
//  A stalled slave therefore cannot hang the debug link.
// PARAMETERS
//  N_MASTERS  2   number of requesting masters (1..8)
//  AW         16  address width
//  DW         32  data width
//  TO_WIDTH   8   timeout counter width; timeout = 2**TO_WIDTH-1 cycles
// PORTS
//  clk      in   1        system clock
//  rst      in   1        synchronous reset, active high
//  m_addr   in   N*AW     master addresses, master i at [i*AW +: AW]
//  m_wdata  in   N*DW     master write data, master i at [i*DW +: DW]
//  m_we     in   N        master write enables
//  m_cyc    in   N        master cycle requests
//  m_ack    out  N        per-master ack, one-hot, single-cycle pulse
//  m_err    out  N        per-master timeout flag, valid with m_ack
//  m_rdata  out  DW       read data shared by all masters, valid with m_ack
//  s_addr   out  AW       slave address (registered)
//  s_wdata  out  DW       slave write data (registered)
//  s_we     out  1        slave write enable (registered)
//  s_cyc    out  1        slave cycle (registered)
//  s_ack    in   1        slave ack
//  s_rdata  in   DW       slave read data
// BEHAVIOUR
//  Reset values: s_cyc=0, s_we=0, s_addr=0, s_wdata=0, state=IDLE.
//  Reset also sets grant=0, prio pointer=0 and timeout counter=0.
//  m_ack, m_err and m_rdata are combinational and therefore 0 in reset.
//  FSM states: IDLE and BUSY.
//  IDLE:
//   - If any m_cyc is high, pick the first requester searching from (last+1) mod N.
//   - Latch that master's addr, wdata and we into s_*. Set s_cyc=1 and go to BUSY.
//   - Latency: m_cyc sampled at edge t gives s_cyc=1 from t+1.
//  BUSY:
//   - Grant is frozen. s_addr, s_wdata and s_we stay stable until exit.
//   - Counter increments each cycle. It is cleared on entry.
//   - s_ack=1: m_ack[g]=1 in the same cycle and m_rdata=s_rdata.
//     Next edge: s_cyc=0, last=g, go to IDLE.
//   - Counter reaches 2**TO_WIDTH-1 without s_ack: m_ack[g]=1, m_err[g]=1 and
//     m_rdata all-ones for one cycle. Next edge: s_cyc=0, last=g, go to IDLE.
//   - s_ack and timeout in the same cycle: s_ack wins, m_err=0.
//   - m_cyc[g] drops before ack (master abort): no m_ack, s_cyc=0 next edge, go to IDLE.
//     The pointer still advances.
//   - Slave ack outside BUSY is ignored. m_ack stays 0.
//  Masters drop cyc in the cycle after ack (classic WB, no pipelining).
//  Bus gap: at least one IDLE cycle between consecutive slave cycles.
//  With N=1 the arbiter degenerates to a registered pass-through with timeout.
//  Fairness: a continuously requesting master waits at most N-1 transactions.
//  Reset asserted mid-BUSY: s_cyc=0 at the next edge. The pending m_ack is never issued.
// TESTING
//  1. Single read: m_cyc[0]=1, s_rdata=0x12345678, ack after 3 cycles ->
//     s_cyc rises 1 cycle after the request and m_ack=01 with m_rdata=0x12345678.
//  2. Contention: both m_cyc high continuously, each ack after 1 cycle ->
//     grants alternate 0,1,0,1 and s_addr alternates between the masters.
//  3. Timeout: TO_WIDTH=4, slave never acks -> m_ack[g]=1, m_err[g]=1 and
//     m_rdata=0xFFFFFFFF exactly 15 cycles after s_cyc rises; s_cyc drops next cycle.
//  4. Write stability: m_we[1]=1, m_wdata=0xCAFEF00D with the master changing
//     its addr/wdata during BUSY -> s_wdata stays 0xCAFEF00D until ack.
//  5. Abort and reset: master 0 drops cyc mid-BUSY -> no ack and master 1 served next.
//     rst pulse during BUSY -> s_cyc=0 next cycle and master 0 has first priority.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one registered slave port.
// The grant is held for a whole bus cycle, and a watchdog ends a cycle the slave never acks.
module wb_rr_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int AW        = 16,
    parameter int DW        = 32,
    parameter int TO_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_MASTERS*AW-1:0] m_addr,
    input  logic [N_MASTERS*DW-1:0] m_wdata,
    input  logic [N_MASTERS-1:0]    m_we,
    input  logic [N_MASTERS-1:0]    m_cyc,
    output logic [N_MASTERS-1:0]    m_ack,
    output logic [N_MASTERS-1:0]    m_err,
    output logic [DW-1:0]           m_rdata,
    output logic [AW-1:0]           s_addr,
    output logic [DW-1:0]           s_wdata,
    output logic                    s_we,
    output logic                    s_cyc,
    input  logic                    s_ack,
    input  logic [DW-1:0]           s_rdata
);

    localparam int                 PW     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam logic [PW-1:0]      LAST   = PW'(N_MASTERS - 1);
    localparam logic [TO_WIDTH-1:0] TO_MAX = '1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              r_state, w_state_nxt;
    logic [PW-1:0]       r_ptr, r_grant, w_pick, w_idx;
    logic                w_found, w_ack, w_timeout, w_abort;
    logic [TO_WIDTH-1:0] r_cnt;
    logic [AW-1:0]       r_s_addr;
    logic [DW-1:0]       r_s_wdata;
    logic                r_s_we, r_s_cyc;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] v);
        return (v == LAST) ? '0 : v + PW'(1);
    endfunction

    // r_ptr is the first master searched, i.e. the one after the last grant.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_idx   = r_ptr;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (!w_found && m_cyc[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
            w_idx = f_inc(w_idx);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 1'b0;
        w_timeout   = 1'b0;
        w_abort     = 1'b0;
        m_ack       = '0;
        m_err       = '0;
        m_rdata     = '0;
        case (r_state)
            IDLE: if (w_found) w_state_nxt = BUSY;
            BUSY: begin
                // A master that has dropped cyc is no longer listening, so it gets no ack.
                if (!m_cyc[r_grant]) begin
                    w_abort = 1'b1;
                end else if (s_ack) begin
                    w_ack            = 1'b1;
                    m_ack[r_grant]   = 1'b1;
                    m_rdata          = s_rdata;
                end else if (r_cnt == TO_MAX) begin
                    w_timeout        = 1'b1;
                    m_ack[r_grant]   = 1'b1;
                    m_err[r_grant]   = 1'b1;
                    m_rdata          = '1;
                end
                if (w_abort || w_ack || w_timeout) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (rst) begin
            m_ack   = '0;
            m_err   = '0;
            m_rdata = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= '0;
            r_grant   <= '0;
            r_cnt     <= '0;
            r_s_addr  <= '0;
            r_s_wdata <= '0;
            r_s_we    <= 1'b0;
            r_s_cyc   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_found) begin
                        r_grant   <= w_pick;
                        r_s_addr  <= m_addr[w_pick*AW +: AW];
                        r_s_wdata <= m_wdata[w_pick*DW +: DW];
                        r_s_we    <= m_we[w_pick];
                        r_s_cyc   <= 1'b1;
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_state_nxt == IDLE) begin
                        r_s_cyc <= 1'b0;
                        r_ptr   <= f_inc(r_grant);
                    end
                end
                default: r_s_cyc <= 1'b0;
            endcase
        end
    end

    assign s_addr  = r_s_addr;
    assign s_wdata = r_s_wdata;
    assign s_we    = r_s_we;
    assign s_cyc   = r_s_cyc;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (2 masters, 4-bit watchdog = 15-cycle timeout).
// Inputs change on the falling edge; outputs are compared 1 ns later.
module tb_wb_rr_arbiter;

    localparam int N  = 2;
    localparam int AW = 16;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N-1:0]    m_we, m_cyc, m_ack, m_err;
    logic [DW-1:0]   m_rdata, s_wdata, s_rdata;
    logic [AW-1:0]   s_addr;
    logic            s_we, s_cyc, s_ack;

    int   n_vec = 0;
    int   n_mis = 0;
    logic exp_g;

    wb_rr_arbiter #(.N_MASTERS(N), .AW(AW), .DW(DW), .TO_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_cyc(m_cyc),
        .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we), .s_cyc(s_cyc),
        .s_ack(s_ack), .s_rdata(s_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; m_addr = '0; m_wdata = '0; m_we = '0; m_cyc = '0;
        s_ack = 1'b1; s_rdata = 32'h5555_AAAA;
        repeat (2) @(negedge clk);
        #1;
        check("rst_s_cyc",   32'(s_cyc),   32'h0);
        check("rst_s_we",    32'(s_we),    32'h0);
        check("rst_s_addr",  32'(s_addr),  32'h0);
        check("rst_s_wdata", s_wdata,      32'h0);
        check("rst_m_ack",   32'(m_ack),   32'h0);
        check("rst_m_rdata", m_rdata,      32'h0);

        // Single read from master 0, slave acks in the third busy cycle
        @(negedge clk);
        rst = 1'b0; s_ack = 1'b0; m_addr[0 +: AW] = 16'h0100; m_cyc = 2'b01;
        #1 check("t1_idle_s_cyc", 32'(s_cyc), 32'h0);
        @(negedge clk); #1;
        check("t1_s_cyc",  32'(s_cyc),  32'h1);
        check("t1_s_addr", 32'(s_addr), 32'h0100);
        check("t1_no_ack", 32'(m_ack),  32'h0);
        @(negedge clk);
        @(negedge clk);
        s_ack = 1'b1; s_rdata = 32'h1234_5678;
        #1;
        check("t1_m_ack",   32'(m_ack), 32'h1);
        check("t1_m_err",   32'(m_err), 32'h0);
        check("t1_m_rdata", m_rdata,    32'h1234_5678);
        @(negedge clk);
        s_ack = 1'b0; m_cyc = 2'b00;
        #1;
        check("t1_s_cyc_drop", 32'(s_cyc), 32'h0);
        check("t1_ack_gone",   32'(m_ack), 32'h0);

        // Contention: master 0 was served last, so master 1 goes first, then alternate
        m_addr[0 +: AW] = 16'h0A00; m_addr[AW +: AW] = 16'h0B00; m_cyc = 2'b11;
        exp_g = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            check("t2_s_cyc",  32'(s_cyc),  32'h1);
            check("t2_s_addr", 32'(s_addr), exp_g ? 32'h0B00 : 32'h0A00);
            s_ack = 1'b1;
            #1 check("t2_m_ack", 32'(m_ack), exp_g ? 32'h2 : 32'h1);
            @(negedge clk);
            s_ack = 1'b0;
            if (k == 3) m_cyc = 2'b00;
            #1 check("t2_gap", 32'(s_cyc), 32'h0);
            exp_g = ~exp_g;
        end

        // Timeout: master 0 alone, slave silent for 15 busy cycles
        @(negedge clk);
        m_addr[0 +: AW] = 16'h0C00; m_cyc = 2'b01;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk); #1;
            if (k == 0)  check("t3_s_cyc",      32'(s_cyc), 32'h1);
            if (k == 14) check("t3_no_ack_c14", 32'(m_ack), 32'h0);
        end
        @(negedge clk); #1;
        check("t3_to_ack",   32'(m_ack), 32'h1);
        check("t3_to_err",   32'(m_err), 32'h1);
        check("t3_to_rdata", m_rdata,    32'hFFFF_FFFF);
        @(negedge clk);
        m_cyc = 2'b00;
        #1;
        check("t3_s_cyc_drop", 32'(s_cyc), 32'h0);
        check("t3_err_gone",   32'(m_err), 32'h0);

        // Ack arriving in the timeout cycle wins: master 1, no error flag
        @(negedge clk);
        m_addr[AW +: AW] = 16'h0C10; m_cyc = 2'b10;
        repeat (16) @(negedge clk);
        s_ack = 1'b1; s_rdata = 32'h0BAD_CAFE;
        #1;
        check("t3b_m_ack",   32'(m_ack), 32'h2);
        check("t3b_m_err",   32'(m_err), 32'h0);
        check("t3b_m_rdata", m_rdata,    32'h0BAD_CAFE);
        @(negedge clk);
        s_ack = 1'b0; m_cyc = 2'b00;
        #1 check("t3b_s_cyc_drop", 32'(s_cyc), 32'h0);

        // Stray slave ack while idle is ignored
        s_ack = 1'b1;
        #1;
        check("idle_ack_ignored", 32'(m_ack), 32'h0);
        check("idle_rdata_zero",  m_rdata,    32'h0);
        @(negedge clk);
        s_ack = 1'b0;

        // Write from master 1; master changes its buses mid-cycle
        m_addr[AW +: AW] = 16'h0D00; m_wdata[DW +: DW] = 32'hCAFE_F00D; m_we = 2'b10; m_cyc = 2'b10;
        @(negedge clk); #1;
        check("t4_s_we",    32'(s_we),   32'h1);
        check("t4_s_wdata", s_wdata,     32'hCAFE_F00D);
        m_wdata[DW +: DW] = 32'hDEAD_BEEF; m_addr[AW +: AW] = 16'hFFFF; m_we = 2'b00;
        @(negedge clk); #1;
        check("t4_hold_wdata", s_wdata,     32'hCAFE_F00D);
        check("t4_hold_addr",  32'(s_addr), 32'h0D00);
        check("t4_hold_we",    32'(s_we),   32'h1);
        @(negedge clk);
        s_ack = 1'b1;
        #1;
        check("t4_m_ack",   32'(m_ack), 32'h2);
        check("t4_ack_wdata", s_wdata,  32'hCAFE_F00D);
        @(negedge clk);
        s_ack = 1'b0; m_cyc = 2'b00;
        #1 check("t4_s_cyc_drop", 32'(s_cyc), 32'h0);

        // Abort: master 0 drops cyc mid-cycle, then master 1 is served next
        m_addr[0 +: AW] = 16'h0E00; m_addr[AW +: AW] = 16'h0F00; m_cyc = 2'b11;
        @(negedge clk); #1;
        check("t5_grant0_addr", 32'(s_addr), 32'h0E00);
        @(negedge clk);
        m_cyc = 2'b10;
        #1 check("t5_abort_no_ack", 32'(m_ack), 32'h0);
        @(negedge clk);
        m_cyc = 2'b11;
        #1 check("t5_abort_s_cyc", 32'(s_cyc), 32'h0);
        @(negedge clk); #1;
        check("t5_next_s_cyc", 32'(s_cyc),  32'h1);
        check("t5_next_addr",  32'(s_addr), 32'h0F00);

        // Reset mid-cycle: no ack, s_cyc drops, master 0 regains first priority
        rst = 1'b1; s_ack = 1'b1;
        #1 check("t5_rst_no_ack", 32'(m_ack), 32'h0);
        @(negedge clk);
        rst = 1'b0; s_ack = 1'b0;
        #1;
        check("t5_rst_s_cyc",  32'(s_cyc),  32'h0);
        check("t5_rst_s_addr", 32'(s_addr), 32'h0);
        @(negedge clk); #1;
        check("t5_prio0_addr", 32'(s_addr), 32'h0E00);
        s_ack = 1'b1;
        #1 check("t5_prio0_ack", 32'(m_ack), 32'h1);
        @(negedge clk);
        s_ack = 1'b0; m_cyc = 2'b00;
        #1 check("t5_end_s_cyc", 32'(s_cyc), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
